// File: rtl/aes_key_expand.sv
// Byte-serial AES-128 key expansion with a 176-byte round-key buffer.
// Loads a 16-byte key, expands one byte per cycle, then streams round keys on request.
module aes_key_expand #(
    parameter int unsigned NROUNDS = 10
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       load_valid,
    input  logic [7:0] key_in,
    output logic       busy,
    output logic       ready,
    input  logic       rd_en,
    input  logic [3:0] rd_round,
    output logic [7:0] rk_out,
    output logic       rk_valid
);
    localparam int unsigned NBYTES = 16 * (NROUNDS + 1);
    localparam int unsigned CW     = $clog2(NBYTES);

    typedef enum logic [1:0] {
        S_LOAD,
        S_EXPAND,
        S_READY
    } state_t;

    // GF(2^8) doubling modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Forward S-box: multiplicative inverse as a^254, then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 2; k < 16; k++) begin
            if (k <= int'(n)) r = xtime(r);
        end
        return r;
    endfunction

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          busy_nxt;
    logic          ready_nxt;

    logic [7:0]    mem [NBYTES];
    logic          wr_en;
    logic [CW-1:0] wr_idx;
    logic [7:0]    wr_data;

    logic [CW-1:0] idx_m16;
    logic [CW-1:0] idx_m4;
    logic [CW-1:0] idx_sb;
    logic [7:0]    sb_out;
    logic [7:0]    rc_byte;
    logic [7:0]    exp_byte;

    logic          rd_active;
    logic [CW-1:0] rd_ptr;
    logic [3:0]    rd_cnt;
    logic          rd_accept;
    logic          abort;

    // Source byte addresses for the expansion byte at cnt
    always_comb begin
        idx_m16 = '0;
        idx_m4  = '0;
        idx_sb  = '0;
        if (state == S_EXPAND) begin
            idx_m16 = cnt - CW'(16);
            idx_m4  = cnt - CW'(4);
            idx_sb  = {cnt[CW-1:2] - (CW-2)'(1), cnt[1:0] + 2'd1};
        end
    end

    assign sb_out  = sbox(mem[idx_sb]);
    assign rc_byte = (cnt[1:0] == 2'd0) ? rcon(4'(cnt >> 4)) : 8'h00;

    always_comb begin
        if (cnt[3:2] == 2'd0) exp_byte = mem[idx_m16] ^ sb_out ^ rc_byte;
        else                  exp_byte = mem[idx_m16] ^ mem[idx_m4];
    end

    // Next-state, buffer write port and status outputs
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wr_en     = 1'b0;
        wr_idx    = cnt;
        wr_data   = key_in;
        case (state)
            S_LOAD: begin
                if (load_valid) begin
                    wr_en   = 1'b1;
                    cnt_nxt = cnt + CW'(1);
                    if (cnt == CW'(15)) state_nxt = S_EXPAND;
                end
            end
            S_EXPAND: begin
                wr_en = 1'b1;
                if (load_valid) begin
                    wr_idx    = '0;
                    cnt_nxt   = CW'(1);
                    state_nxt = S_LOAD;
                end else begin
                    wr_data = exp_byte;
                    cnt_nxt = cnt + CW'(1);
                    if (cnt == CW'(NBYTES - 1)) state_nxt = S_READY;
                end
            end
            S_READY: begin
                if (load_valid) begin
                    wr_en     = 1'b1;
                    wr_idx    = '0;
                    cnt_nxt   = CW'(1);
                    state_nxt = S_LOAD;
                end
            end
            default: begin
                state_nxt = S_LOAD;
                cnt_nxt   = '0;
            end
        endcase
        busy_nxt  = (state_nxt != S_READY) && !((state_nxt == S_LOAD) && (cnt_nxt == '0));
        ready_nxt = (state_nxt == S_READY);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_LOAD;
            cnt   <= '0;
            busy  <= 1'b0;
            ready <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= busy_nxt;
            ready <= ready_nxt;
        end
    end

    // Buffer contents are not reset
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    // A new request is taken when idle or while the last byte of a stream goes out
    assign abort     = load_valid && (state != S_LOAD);
    assign rd_accept = (state == S_READY) && !load_valid && rd_en
                       && (rd_round <= 4'(NROUNDS))
                       && (!rd_active || (rd_cnt == 4'd15));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_active <= 1'b0;
            rd_ptr    <= '0;
            rd_cnt    <= '0;
            rk_out    <= 8'h00;
            rk_valid  <= 1'b0;
        end else if (abort) begin
            rd_active <= 1'b0;
            rk_out    <= 8'h00;
            rk_valid  <= 1'b0;
        end else begin
            if (rd_active) begin
                rk_out   <= mem[rd_ptr];
                rk_valid <= 1'b1;
                rd_ptr   <= rd_ptr + CW'(1);
                rd_cnt   <= rd_cnt + 4'd1;
            end else begin
                rk_out   <= 8'h00;
                rk_valid <= 1'b0;
            end
            if (rd_accept) begin
                rd_active <= 1'b1;
                rd_ptr    <= CW'({rd_round, 4'h0});
                rd_cnt    <= 4'd0;
            end else if (rd_active && (rd_cnt == 4'd15)) begin
                rd_active <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: word-level AES-128 key schedule model, FIPS-197 vectors,
// random keys, back-to-back streams, reload aborts and asynchronous reset.
module tb_aes_key_expand;
    localparam int unsigned NR = 10;
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       load_valid;
    logic [7:0] key_in;
    logic       busy;
    logic       ready;
    logic       rd_en;
    logic [3:0] rd_round;
    logic [7:0] rk_out;
    logic       rk_valid;

    int tests = 0;
    int fails = 0;

    logic [7:0]  sbox_t [256];
    logic [31:0] w [44];

    aes_key_expand #(.NROUNDS(NR)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .load_valid(load_valid),
        .key_in    (key_in),
        .busy      (busy),
        .ready     (ready),
        .rd_en     (rd_en),
        .rd_round  (rd_round),
        .rk_out    (rk_out),
        .rk_valid  (rk_valid)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Polynomial product then reduction by 0x11b
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
            sbox_t[x] = s ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
    endtask

    function automatic logic [127:0] model_rk(input int r);
        return {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drives key bytes first..15; ok drops if busy/ready/rk_valid misbehave while loading
    task automatic load_bytes(input logic [127:0] key, input int first, input bit gaps, output bit ok);
        ok = 1'b1;
        for (int j = first; j < 16; j++) begin
            if (gaps && j != first) begin
                load_valid = 1'b0;
                step();
                if (busy !== 1'b1 || ready !== 1'b0 || rk_valid !== 1'b0) ok = 1'b0;
            end
            load_valid = 1'b1;
            key_in     = key[127 - 8 * j -: 8];
            step();
            if (busy !== 1'b1 || ready !== 1'b0 || rk_valid !== 1'b0) ok = 1'b0;
        end
        load_valid = 1'b0;
    endtask

    // Cycle 1 is the cycle after the last key byte is sampled
    task automatic wait_ready(output int ready_cyc, output bit busy_ok);
        ready_cyc = -1;
        busy_ok   = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            if (ready === 1'b1) begin
                ready_cyc = c;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            step();
        end
    endtask

    task automatic read_round(input logic [3:0] r, output logic [127:0] data, output bit shape_ok);
        data     = '0;
        shape_ok = 1'b1;
        rd_en    = 1'b1;
        rd_round = r;
        step();
        rd_en = 1'b0;
        if (rk_valid !== 1'b0) shape_ok = 1'b0;
        for (int t = 1; t <= 16; t++) begin
            step();
            if (rk_valid !== 1'b1) shape_ok = 1'b0;
            data = {data[119:0], rk_out};
        end
        step();
        if (rk_valid !== 1'b0) shape_ok = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) step();
        tests++;
        if ({busy, ready, rk_valid, rk_out} !== 11'h0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b ready=%b rk_valid=%b rk_out=%h, want all 0", busy, ready, rk_valid, rk_out);
        end
        @(negedge clock);
        reset_n = 1'b1;
        step();
        step();
        tests++;
        if ({busy, ready, rk_valid} !== 3'b000) begin
            fails++;
            $display("FAIL idle_after_reset: busy=%b ready=%b rk_valid=%b, want 000", busy, ready, rk_valid);
        end
    endtask

    task automatic test_fips_load();
        bit ok_l, ok_w;
        int rc;
        model_expand(FIPS_KEY);
        load_bytes(FIPS_KEY, 0, 1'b0, ok_l);
        wait_ready(rc, ok_w);
        tests++;
        if (rc !== 161) begin
            fails++;
            $display("FAIL fips_ready_latency: got %0d cycles, want 161", rc);
        end
        tests++;
        if (!(ok_l && ok_w) || busy !== 1'b0) begin
            fails++;
            $display("FAIL fips_busy: load_ok=%b expand_ok=%b busy_at_ready=%b, want 1 1 0", ok_l, ok_w, busy);
        end
    endtask

    task automatic test_read_r10();
        logic [127:0] d;
        bit shape;
        read_round(4'd10, d, shape);
        tests++;
        if (d !== FIPS_R10) begin
            fails++;
            $display("FAIL r10_fips: got %h want %h", d, FIPS_R10);
        end
        tests++;
        if (!shape) begin
            fails++;
            $display("FAIL r10_valid_window: rk_valid not high for exactly cycles 1..16, want 16-cycle window");
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] got;
        bit ok;
        got = '0;
        ok  = 1'b1;
        for (int t = 0; t <= 34; t++) begin
            rd_en = (t == 0 || t == 5 || t == 16);
            if (t == 0)      rd_round = 4'd1;
            else if (t == 5) rd_round = 4'd7;
            else             rd_round = 4'd0;
            step();
            if (t >= 1 && t <= 32) begin
                if (rk_valid !== 1'b1) ok = 1'b0;
                got = {got[247:0], rk_out};
            end else if (rk_valid !== 1'b0) begin
                ok = 1'b0;
            end
        end
        rd_en = 1'b0;
        tests++;
        if (got !== {FIPS_R1, FIPS_KEY}) begin
            fails++;
            $display("FAIL b2b_fips: got %h want %h", got, {FIPS_R1, FIPS_KEY});
        end
        tests++;
        if (got !== {model_rk(1), model_rk(0)}) begin
            fails++;
            $display("FAIL b2b_model: got %h want %h", got, {model_rk(1), model_rk(0)});
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL b2b_gapless: rk_valid pattern wrong, want high exactly cycles 1..32");
        end
    endtask

    task automatic test_bad_round();
        bit ok;
        ok = 1'b1;
        for (int t = 0; t < 24; t++) begin
            rd_en    = (t == 0 || t == 3);
            rd_round = (t == 0) ? 4'd11 : 4'd15;
            step();
            if (rk_valid !== 1'b0) ok = 1'b0;
        end
        rd_en = 1'b0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL bad_round: rk_valid rose for rd_round>%0d, want 0", NR);
        end
    endtask

    task automatic test_gapped_load();
        logic [127:0] d;
        bit ok_l, ok_w, shape, all_ok;
        int rc;
        load_bytes(FIPS_KEY, 0, 1'b1, ok_l);
        wait_ready(rc, ok_w);
        tests++;
        if (rc !== 161 || !(ok_l && ok_w)) begin
            fails++;
            $display("FAIL gapped_ready: latency=%0d ok=%b%b, want 161 and 11", rc, ok_l, ok_w);
        end
        all_ok = 1'b1;
        for (int r = 0; r <= 10; r++) begin
            read_round(4'(r), d, shape);
            if (d !== model_rk(r) || !shape) all_ok = 1'b0;
        end
        tests++;
        if (!all_ok) begin
            fails++;
            $display("FAIL gapped_rounds: some round key differs from contiguous-load schedule");
        end
    endtask

    task automatic test_random_keys();
        logic [127:0] key, d;
        bit ok_l, ok_w, shape;
        int rc;
        for (int n = 0; n < 3; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            model_expand(key);
            load_bytes(key, 0, 1'($urandom_range(0, 1)), ok_l);
            wait_ready(rc, ok_w);
            tests++;
            if (rc !== 161 || !(ok_l && ok_w)) begin
                fails++;
                $display("FAIL rand_ready key=%h: latency=%0d ok=%b%b, want 161 and 11", key, rc, ok_l, ok_w);
            end
            for (int r = 10; r >= 0; r--) begin
                read_round(4'(r), d, shape);
                tests++;
                if (d !== model_rk(r) || !shape) begin
                    fails++;
                    $display("FAIL rand_round%0d key=%h: got %h shape=%b want %h shape=1", r, key, d, shape, model_rk(r));
                end
            end
        end
    endtask

    task automatic test_abort_expand();
        logic [127:0] key_a, d;
        bit ok_a, ok_z, ok_w, ok_mid, shape;
        int rc;
        key_a  = {$urandom, $urandom, $urandom, $urandom};
        ok_mid = 1'b1;
        load_bytes(key_a, 0, 1'b0, ok_a);
        for (int c = 1; c < 50; c++) begin
            if (ready !== 1'b0 || busy !== 1'b1) ok_mid = 1'b0;
            step();
        end
        model_expand(128'h0);
        load_bytes(128'h0, 0, 1'b0, ok_z);
        wait_ready(rc, ok_w);
        tests++;
        if (rc !== 161 || !(ok_a && ok_z && ok_w && ok_mid)) begin
            fails++;
            $display("FAIL abort_expand_ready: latency=%0d ok=%b%b%b%b, want 161 and 1111", rc, ok_a, ok_z, ok_w, ok_mid);
        end
        read_round(4'd10, d, shape);
        tests++;
        if (d !== ZERO_R10 || d !== model_rk(10) || !shape) begin
            fails++;
            $display("FAIL abort_expand_r10: got %h shape=%b want %h", d, shape, ZERO_R10);
        end
    endtask

    task automatic test_abort_stream();
        logic [127:0] key_b, d;
        bit ok_l, ok_w, shape;
        int rc, r;
        key_b    = {$urandom, $urandom, $urandom, $urandom};
        rd_en    = 1'b1;
        rd_round = 4'd10;
        step();
        rd_en = 1'b0;
        repeat (5) step();
        load_valid = 1'b1;
        key_in     = key_b[127:120];
        rd_en      = 1'b1;
        rd_round   = 4'd3;
        step();
        rd_en = 1'b0;
        tests++;
        if ({rk_valid, rk_out, ready, busy} !== 11'b0_00000000_0_1) begin
            fails++;
            $display("FAIL abort_stream: rk_valid=%b rk_out=%h ready=%b busy=%b, want 0 00 0 1", rk_valid, rk_out, ready, busy);
        end
        model_expand(key_b);
        load_bytes(key_b, 1, 1'b0, ok_l);
        wait_ready(rc, ok_w);
        r = $urandom_range(0, 10);
        read_round(4'(r), d, shape);
        tests++;
        if (rc !== 161 || !(ok_l && ok_w) || d !== model_rk(r) || !shape) begin
            fails++;
            $display("FAIL reload_after_abort: latency=%0d ok=%b%b round%0d=%h want 161 11 %h", rc, ok_l, ok_w, r, d, model_rk(r));
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] key_c, d;
        bit ok_l, ok_w, shape;
        int rc;
        rd_en    = 1'b1;
        rd_round = 4'd5;
        step();
        rd_en = 1'b0;
        repeat (4) step();
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if ({busy, ready, rk_valid, rk_out} !== 11'h0) begin
            fails++;
            $display("FAIL async_reset: busy=%b ready=%b rk_valid=%b rk_out=%h, want all 0", busy, ready, rk_valid, rk_out);
        end
        @(negedge clock);
        reset_n = 1'b1;
        step();
        key_c = {$urandom, $urandom, $urandom, $urandom};
        model_expand(key_c);
        load_bytes(key_c, 0, 1'b0, ok_l);
        wait_ready(rc, ok_w);
        read_round(4'd5, d, shape);
        tests++;
        if (rc !== 161 || !(ok_l && ok_w) || d !== model_rk(5) || !shape) begin
            fails++;
            $display("FAIL post_reset_load: latency=%0d ok=%b%b round5=%h want 161 11 %h", rc, ok_l, ok_w, d, model_rk(5));
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        load_valid = 1'b0;
        key_in     = 8'h00;
        rd_en      = 1'b0;
        rd_round   = 4'd0;
        build_sbox();
        test_reset();
        test_fips_load();
        test_read_r10();
        test_back_to_back();
        test_bad_round();
        test_gapped_load();
        test_random_keys();
        test_abort_expand();
        test_abort_stream();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
